rv32_int_muldiv: RTL

RV32_INT_MULDIV -- requirements
Module: rv32_int_muldiv

---
 rtl/rv32_int_muldiv.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rv32_int_muldiv.sv
// Iterative RISC-V M-extension multiply/divide: one radix-2 step per cycle, valid/ready on both sides.
// Define RV32_MULDIV_EARLY_OUT_EN to let trivial cases (zero multiply, divide-by-zero, signed overflow) skip to DONE.
module rv32_int_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [2:0]      operation,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_opsel_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(XLEN + 1);

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  muldiv_opsel_t   r_op;
  logic            r_neg;
  logic            r_rneg;
  logic            r_dz;

  muldiv_opsel_t   w_op;
  logic            w_is_div;
  logic            w_a_sgn;
  logic            w_b_sgn;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_accept;
  logic            w_dz;
  logic            w_early;
  logic [XLEN:0]   w_madd;
  logic [XLEN:0]   w_dsh;
  logic [XLEN:0]   w_dsub;
  logic            w_dfit;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_res;

  assign w_op     = muldiv_opsel_t'(operation);
  assign w_is_div = operation[2];
  assign w_a_sgn  = op1[XLEN-1] & ((w_op == MULH) | (w_op == MULHSU) | (w_op == DIV) | (w_op == REM));
  assign w_b_sgn  = op2[XLEN-1] & ((w_op == MULH) | (w_op == DIV) | (w_op == REM));
  assign w_a_mag  = w_a_sgn ? -op1 : op1;
  assign w_b_mag  = w_b_sgn ? -op2 : op2;
  assign w_accept = in_valid && (r_state == S_IDLE) && !kill;
  assign w_dz     = w_is_div && (op2 == '0);

`ifdef RV32_MULDIV_EARLY_OUT_EN
  logic w_ovf;
  assign w_ovf   = w_is_div && !operation[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (&op2);
  assign w_early = (!w_is_div && ((op1 == '0) || (op2 == '0))) || w_dz || w_ovf;
`else
  assign w_early = 1'b0;
`endif

  // Multiply: {r_hi,r_lo} shifts right with r_lo holding the multiplier; divide: shifts left, r_lo collects quotient bits.
  assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
  assign w_dsh  = {r_hi, r_lo[XLEN-1]};
  assign w_dsub = w_dsh - {1'b0, r_b};
  assign w_dfit = !w_dsub[XLEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_op    <= MUL;
      r_neg   <= 1'b0;
      r_rneg  <= 1'b0;
      r_dz    <= 1'b0;
    end else if (kill) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= w_op;
            r_neg  <= w_a_sgn ^ w_b_sgn;
            r_rneg <= w_a_sgn;
            r_dz   <= w_dz;
            r_b    <= w_is_div ? w_b_mag : w_a_mag;
            if (w_early) begin
              // Preload the registers so the shared result mux yields the architectural answer.
              r_state <= S_DONE;
              r_cnt   <= '0;
              r_hi    <= w_dz ? w_a_mag : '0;
              r_lo    <= w_dz ? '1 : (w_is_div ? w_a_mag : '0);
            end else begin
              r_state <= S_RUN;
              r_cnt   <= CW'(XLEN);
              r_hi    <= '0;
              r_lo    <= w_is_div ? w_a_mag : w_b_mag;
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_DONE;
          if (r_op[2]) begin
            r_hi <= w_dfit ? w_dsub[XLEN-1:0] : w_dsh[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], w_dfit};
          end else begin
            r_hi <= w_madd[XLEN:1];
            r_lo <= {w_madd[0], r_lo[XLEN-1:1]};
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_quo    = r_dz ? '1 : (r_neg ? -r_lo : r_lo);
  assign w_rem    = r_rneg ? -r_hi : r_hi;

  always_comb begin
    w_res = '0;
    case (r_op)
      MUL:                 w_res = w_prod_s[XLEN-1:0];
      MULH, MULHSU, MULHU: w_res = w_prod_s[2*XLEN-1:XLEN];
      DIV, DIVU:           w_res = w_quo;
      default:             w_res = w_rem;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = out_valid ? w_res : '0;

endmodule
